mem_port_arbiter: RTL and testbench

Shares the single refill memory port between the instruction-fetch miss path and the data-cache miss/write path of the datapath. Accepts at most one transaction at a time and arbitrates round-robin between the two requesters. Forwards the granted request to memory and routes the response back to the correct requester. A watchdog terminates transactions whose memory response never arrives.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one refill memory port between the
//               fetch miss path and the data-cache miss/write path, with a
//               response watchdog.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 40,
   parameter int LINE_WIDTH     = 128,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  ic_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
   output logic                  ic_req_ready_o,
   output logic                  ic_resp_valid_o,
   output logic [LINE_WIDTH-1:0] ic_resp_data_o,
   input  logic                  dc_req_valid_i,
   input  logic                  dc_req_we_i,
   input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
   input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
   output logic                  dc_req_ready_o,
   output logic                  dc_resp_valid_o,
   output logic [LINE_WIDTH-1:0] dc_resp_data_o,
   output logic                  resp_error_o,
   output logic                  mem_req_valid_o,
   output logic                  mem_req_we_o,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   output logic [LINE_WIDTH-1:0] mem_req_wdata_o,
   input  logic                  mem_req_ready_i,
   input  logic                  mem_resp_valid_i,
   input  logic [LINE_WIDTH-1:0] mem_resp_data_i,
   output logic                  busy_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_issue = 2'd1;
   localparam logic [1:0] c_wait  = 2'd2;
   localparam logic [1:0] c_resp  = 2'd3;

   localparam logic c_own_ic = 1'b0;
   localparam logic c_own_dc = 1'b1;

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]            r_state;
   logic                  r_owner;
   logic                  r_last_grant;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic [LINE_WIDTH-1:0] r_data;
   logic                  r_error;
   logic [CNT_W-1:0]      r_cnt;

   logic w_idle;
   logic w_grant_ic;
   logic w_grant_dc;

   // On a tie, the side that did not win last time gets the port.
   assign w_idle     = (r_state == c_idle);
   assign w_grant_ic = ic_req_valid_i & (~dc_req_valid_i | (r_last_grant == c_own_dc));
   assign w_grant_dc = dc_req_valid_i & (~ic_req_valid_i | (r_last_grant == c_own_ic));

   assign ic_req_ready_o  = w_idle & w_grant_ic;
   assign dc_req_ready_o  = w_idle & w_grant_dc;

   assign mem_req_valid_o = (r_state == c_issue);
   assign mem_req_we_o    = r_we;
   assign mem_req_addr_o  = r_addr;
   assign mem_req_wdata_o = r_wdata;

   assign ic_resp_valid_o = (r_state == c_resp) & (r_owner == c_own_ic);
   assign dc_resp_valid_o = (r_state == c_resp) & (r_owner == c_own_dc);
   assign ic_resp_data_o  = r_data;
   assign dc_resp_data_o  = r_data;
   assign resp_error_o    = (r_state == c_resp) & r_error;

   assign busy_o = ~w_idle;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= c_idle;
         r_owner      <= c_own_ic;
         r_last_grant <= c_own_dc;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_data       <= '0;
         r_error      <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (ic_req_ready_o) begin
                  r_owner      <= c_own_ic;
                  r_last_grant <= c_own_ic;
                  r_we         <= 1'b0;
                  r_addr       <= ic_req_addr_i;
                  r_wdata      <= '0;
                  r_state      <= c_issue;
               end else if (dc_req_ready_o) begin
                  r_owner      <= c_own_dc;
                  r_last_grant <= c_own_dc;
                  r_we         <= dc_req_we_i;
                  r_addr       <= dc_req_addr_i;
                  r_wdata      <= dc_req_wdata_i;
                  r_state      <= c_issue;
               end
            end
            c_issue: begin
               if (mem_req_ready_i) begin
                  r_cnt   <= '0;
                  r_state <= c_wait;
               end
            end
            c_wait: begin
               // A response arriving on the final watchdog cycle still wins.
               if (mem_resp_valid_i) begin
                  r_data  <= r_we ? '0 : mem_resp_data_i;
                  r_error <= 1'b0;
                  r_state <= c_resp;
               end else if (r_cnt == c_cnt_last) begin
                  r_data  <= '0;
                  r_error <= 1'b1;
                  r_state <= c_resp;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            c_resp: begin
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

   localparam int AW = 40;
   localparam int LW = 128;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          ic_req_valid_i;
   logic [AW-1:0] ic_req_addr_i;
   logic          ic_req_ready_o;
   logic          ic_resp_valid_o;
   logic [LW-1:0] ic_resp_data_o;
   logic          dc_req_valid_i;
   logic          dc_req_we_i;
   logic [AW-1:0] dc_req_addr_i;
   logic [LW-1:0] dc_req_wdata_i;
   logic          dc_req_ready_o;
   logic          dc_resp_valid_o;
   logic [LW-1:0] dc_resp_data_o;
   logic          resp_error_o;
   logic          mem_req_valid_o;
   logic          mem_req_we_o;
   logic [AW-1:0] mem_req_addr_o;
   logic [LW-1:0] mem_req_wdata_o;
   logic          mem_req_ready_i;
   logic          mem_resp_valid_i;
   logic [LW-1:0] mem_resp_data_i;
   logic          busy_o;

   int n_checks = 0;
   int n_errors = 0;
   logic dc_seen;

   mem_port_arbiter #(
      .ADDR_WIDTH    (AW),
      .LINE_WIDTH    (LW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .ic_req_valid_i  (ic_req_valid_i),
      .ic_req_addr_i   (ic_req_addr_i),
      .ic_req_ready_o  (ic_req_ready_o),
      .ic_resp_valid_o (ic_resp_valid_o),
      .ic_resp_data_o  (ic_resp_data_o),
      .dc_req_valid_i  (dc_req_valid_i),
      .dc_req_we_i     (dc_req_we_i),
      .dc_req_addr_i   (dc_req_addr_i),
      .dc_req_wdata_i  (dc_req_wdata_i),
      .dc_req_ready_o  (dc_req_ready_o),
      .dc_resp_valid_o (dc_resp_valid_o),
      .dc_resp_data_o  (dc_resp_data_o),
      .resp_error_o    (resp_error_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_we_o    (mem_req_we_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_resp_valid_i(mem_resp_valid_i),
      .mem_resp_data_i (mem_resp_data_i),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (dc_resp_valid_o) dc_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      rstn_i = 1'b0;
      tick();
      tick();
      rstn_i = 1'b1;
      #1;
   endtask

   // Drives one fetch request through accept and memory handshake, leaving the DUT in WAIT.
   task automatic ic_to_wait(input logic [AW-1:0] addr);
      ic_req_valid_i  = 1'b1;
      ic_req_addr_i   = addr;
      mem_req_ready_i = 1'b1;
      tick();
      ic_req_valid_i = 1'b0;
      tick();
   endtask

   initial begin
      ic_req_valid_i   = 1'b0;
      ic_req_addr_i    = '0;
      dc_req_valid_i   = 1'b0;
      dc_req_we_i      = 1'b0;
      dc_req_addr_i    = '0;
      dc_req_wdata_i   = '0;
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
      dc_seen          = 1'b0;
      rstn_i           = 1'b1;
      #2;
      apply_reset();

      check_eq("reset_busy", LW'(busy_o), LW'(0));
      check_eq("reset_mem_valid", LW'(mem_req_valid_o), LW'(0));
      check_eq("reset_resp", LW'({ic_resp_valid_o, dc_resp_valid_o, resp_error_o}), LW'(0));

      // Fetch only
      dc_seen         = 1'b0;
      ic_req_valid_i  = 1'b1;
      ic_req_addr_i   = 40'h1000;
      mem_req_ready_i = 1'b1;
      #1;
      check_eq("t1_ic_ready", LW'({ic_req_ready_o, dc_req_ready_o}), LW'(2'b10));
      check_eq("t1_mem_valid_c0", LW'(mem_req_valid_o), LW'(0));
      tick();
      ic_req_valid_i = 1'b0;
      check_eq("t1_mem_valid_c1", LW'(mem_req_valid_o), LW'(1));
      check_eq("t1_mem_addr", LW'(mem_req_addr_o), LW'(40'h1000));
      check_eq("t1_mem_we", LW'(mem_req_we_o), LW'(0));
      tick();
      check_eq("t1_wait_no_resp", LW'(ic_resp_valid_o), LW'(0));
      tick();
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = {16{8'hA5}};
      tick();
      mem_resp_valid_i = 1'b0;
      check_eq("t1_ic_resp_valid", LW'(ic_resp_valid_o), LW'(1));
      check_eq("t1_ic_resp_data", ic_resp_data_o, {16{8'hA5}});
      check_eq("t1_resp_error", LW'(resp_error_o), LW'(0));
      tick();
      check_eq("t1_resp_pulse_end", LW'(ic_resp_valid_o), LW'(0));
      check_eq("t1_busy_idle", LW'(busy_o), LW'(0));
      check_eq("t1_dc_resp_never", LW'(dc_seen), LW'(0));

      // Round robin with both requesters held valid
      apply_reset();
      ic_req_valid_i  = 1'b1;
      ic_req_addr_i   = 40'h100;
      dc_req_valid_i  = 1'b1;
      dc_req_we_i     = 1'b0;
      dc_req_addr_i   = 40'h200;
      mem_req_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         logic exp_ic;
         exp_ic = (i % 2 == 0);
         check_eq($sformatf("rr%0d_ready", i), LW'({ic_req_ready_o, dc_req_ready_o}), LW'({exp_ic, ~exp_ic}));
         tick();
         check_eq($sformatf("rr%0d_addr", i), LW'(mem_req_addr_o), exp_ic ? LW'(40'h100) : LW'(40'h200));
         tick();
         mem_resp_valid_i = 1'b1;
         mem_resp_data_i  = LW'(i + 7);
         tick();
         mem_resp_valid_i = 1'b0;
         check_eq($sformatf("rr%0d_resp", i), LW'({ic_resp_valid_o, dc_resp_valid_o}), LW'({exp_ic, ~exp_ic}));
         check_eq($sformatf("rr%0d_data", i), exp_ic ? ic_resp_data_o : dc_resp_data_o, LW'(i + 7));
         tick();
      end
      ic_req_valid_i = 1'b0;
      dc_req_valid_i = 1'b0;

      // Data write with memory back-pressure
      dc_req_valid_i  = 1'b1;
      dc_req_we_i     = 1'b1;
      dc_req_addr_i   = 40'h2040;
      dc_req_wdata_i  = LW'(16'h1234);
      mem_req_ready_i = 1'b0;
      #1;
      check_eq("t3_dc_ready", LW'({ic_req_ready_o, dc_req_ready_o}), LW'(2'b01));
      tick();
      dc_req_valid_i = 1'b0;
      dc_req_wdata_i = '0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) mem_req_ready_i = 1'b1;
         #1;
         check_eq($sformatf("t3_hold%0d", k),
                  LW'({mem_req_valid_o, mem_req_we_o, mem_req_addr_o}), LW'({2'b11, 40'h2040}));
         check_eq($sformatf("t3_wdata%0d", k), mem_req_wdata_o, LW'(16'h1234));
         tick();
      end
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = {8{16'hFFFF}};
      tick();
      mem_resp_valid_i = 1'b0;
      check_eq("t3_dc_ack", LW'({ic_resp_valid_o, dc_resp_valid_o, resp_error_o}), LW'(3'b010));
      check_eq("t3_dc_data", dc_resp_data_o, LW'(0));
      tick();

      // Timeout with no memory response
      mem_resp_data_i = {4{32'hCAFEF00D}};
      ic_to_wait(40'h3000);
      check_eq("t4_wait0", LW'({busy_o, ic_resp_valid_o}), LW'(2'b10));
      for (int n = 1; n < 8; n++) begin
         tick();
         check_eq($sformatf("t4_wait%0d", n), LW'({busy_o, ic_resp_valid_o}), LW'(2'b10));
      end
      tick();
      check_eq("t4_timeout_pulse", LW'({ic_resp_valid_o, dc_resp_valid_o, resp_error_o}), LW'(3'b101));
      check_eq("t4_timeout_data", ic_resp_data_o, LW'(0));
      tick();
      tick();
      mem_resp_valid_i = 1'b1;
      tick();
      mem_resp_valid_i = 1'b0;
      check_eq("t4_stray_ignored", LW'({busy_o, ic_resp_valid_o, dc_resp_valid_o}), LW'(0));

      // Response on the final watchdog cycle
      ic_to_wait(40'h4000);
      for (int n = 1; n < 8; n++) tick();
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = LW'(32'hDEAD);
      tick();
      mem_resp_valid_i = 1'b0;
      check_eq("t5_edge_resp", LW'({ic_resp_valid_o, resp_error_o}), LW'(2'b10));
      check_eq("t5_edge_data", ic_resp_data_o, LW'(32'hDEAD));
      tick();

      // Asynchronous reset during WAIT
      ic_to_wait(40'h5000);
      check_eq("t6_in_wait", LW'(busy_o), LW'(1));
      #1;
      rstn_i = 1'b0;
      #1;
      check_eq("t6_rst_ctrl", LW'({busy_o, mem_req_valid_o, mem_req_we_o, ic_resp_valid_o,
                                   dc_resp_valid_o, resp_error_o, ic_req_ready_o, dc_req_ready_o}), LW'(0));
      check_eq("t6_rst_addr", LW'(mem_req_addr_o), LW'(0));
      mem_resp_valid_i = 1'b1;
      tick();
      mem_resp_valid_i = 1'b0;
      check_eq("t6_rst_no_resp", LW'({ic_resp_valid_o, dc_resp_valid_o}), LW'(0));
      rstn_i         = 1'b1;
      ic_req_valid_i = 1'b1;
      dc_req_valid_i = 1'b1;
      dc_req_we_i    = 1'b0;
      #1;
      check_eq("t6_ic_first", LW'({ic_req_ready_o, dc_req_ready_o}), LW'(2'b10));
      check_eq("t6_no_resp_after", LW'({ic_resp_valid_o, dc_resp_valid_o}), LW'(0));
      ic_req_valid_i = 1'b0;
      dc_req_valid_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
